// File: rtl/ray_pkg.sv
// Shared types for the ray job dispatcher.
// Job bundle layout and dispatcher state encoding.
package ray_pkg;

  localparam int RAY_X_BITS = 5;
  localparam int RAY_Y_BITS = 5;
  localparam int RAY_Z_BITS = 5;
  localparam int RAY_TIMER_WIDTH = 32;
  localparam int RAY_STEP_WIDTH = 16;
  localparam int RAY_ID_WIDTH = 4;

  typedef struct packed {
    logic [RAY_X_BITS-1:0]      init_x;
    logic [RAY_Y_BITS-1:0]      init_y;
    logic [RAY_Z_BITS-1:0]      init_z;
    logic [RAY_TIMER_WIDTH-1:0] timer_x;
    logic [RAY_TIMER_WIDTH-1:0] timer_y;
    logic [RAY_TIMER_WIDTH-1:0] timer_z;
    logic [RAY_STEP_WIDTH-1:0]  max_steps;
    logic [RAY_ID_WIDTH-1:0]    job_id;
  } ray_job_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } dispatch_state_t;

endpackage

// File: rtl/ray_job_fifo.sv
// Register-array job FIFO with synchronous flush.
// Read data is the head entry; no write-to-read bypass.
module ray_job_fifo
  import ray_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ray_job_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  input  logic flush,
  output T     pop_data,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ray_job_dispatch.sv
// Ray job dispatcher feeding step_control_fsm.
// Queues jobs, presents one, holds it through FSM INIT.
module ray_job_dispatch
  import ray_pkg::*;
#(
  parameter int X_BITS           = 5,
  parameter int Y_BITS           = 5,
  parameter int Z_BITS           = 5,
  parameter int TIMER_WIDTH      = 32,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int DEPTH            = 4,
  parameter int ID_WIDTH         = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [X_BITS-1:0] in_init_x,
  input  logic [Y_BITS-1:0] in_init_y,
  input  logic [Z_BITS-1:0] in_init_z,
  input  logic [TIMER_WIDTH-1:0] in_timer_x,
  input  logic [TIMER_WIDTH-1:0] in_timer_y,
  input  logic [TIMER_WIDTH-1:0] in_timer_z,
  input  logic [STEP_COUNT_WIDTH-1:0] in_max_steps,
  input  logic [ID_WIDTH-1:0] in_job_id,
  input  logic flush,
  input  logic fsm_ready,
  output logic job_loaded,
  output logic [X_BITS-1:0] job_init_x,
  output logic [Y_BITS-1:0] job_init_y,
  output logic [Z_BITS-1:0] job_init_z,
  output logic [TIMER_WIDTH-1:0] job_timer_x,
  output logic [TIMER_WIDTH-1:0] job_timer_y,
  output logic [TIMER_WIDTH-1:0] job_timer_z,
  output logic [STEP_COUNT_WIDTH-1:0] max_steps,
  output logic [ID_WIDTH-1:0] job_id,
  output logic [$clog2(DEPTH+1):0] jobs_pending,
  output logic busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = CW + 1;

  typedef struct packed {
    logic [X_BITS-1:0]           init_x;
    logic [Y_BITS-1:0]           init_y;
    logic [Z_BITS-1:0]           init_z;
    logic [TIMER_WIDTH-1:0]      timer_x;
    logic [TIMER_WIDTH-1:0]      timer_y;
    logic [TIMER_WIDTH-1:0]      timer_z;
    logic [STEP_COUNT_WIDTH-1:0] max_steps;
    logic [ID_WIDTH-1:0]         job_id;
  } job_t;

  dispatch_state_t state;
  job_t in_job;
  job_t head_job;
  job_t job_q;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic [CW-1:0] fifo_count;
  logic active;

  assign in_job = '{
    init_x:    in_init_x,
    init_y:    in_init_y,
    init_z:    in_init_z,
    timer_x:   in_timer_x,
    timer_y:   in_timer_y,
    timer_z:   in_timer_z,
    max_steps: in_max_steps,
    job_id:    in_job_id
  };

  ray_job_fifo #(
    .DEPTH (DEPTH),
    .T     (job_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_job),
    .pop       (fifo_pop),
    .flush     (flush),
    .pop_data  (head_job),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign active   = (state != EMPTY);
  assign fifo_pop = !flush && !fifo_empty
                    && ((state == EMPTY) || (state == HOLD));

  // HOLD already committed the job, so flush cannot cancel it.
  assign job_loaded   = (state == PRESENT) && fsm_ready && !flush;
  assign in_ready     = !fifo_full;
  assign busy         = active || !fifo_empty;
  assign jobs_pending = PW'(fifo_count) + PW'(active);

  // Dispatcher state and presented job; regs load only on a pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      job_q <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (fifo_pop) begin
            job_q <= head_job;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (flush)          state <= EMPTY;
          else if (fsm_ready) state <= HOLD;
        end
        HOLD: begin
          if (fifo_pop) begin
            job_q <= head_job;
            state <= PRESENT;
          end else begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign job_init_x  = job_q.init_x;
  assign job_init_y  = job_q.init_y;
  assign job_init_z  = job_q.init_z;
  assign job_timer_x = job_q.timer_x;
  assign job_timer_y = job_q.timer_y;
  assign job_timer_z = job_q.timer_z;
  assign max_steps   = job_q.max_steps;
  assign job_id      = job_q.job_id;

endmodule

// File: tb/tb_ray_job_dispatch.sv
// Self-checking bench for ray_job_dispatch.
// Scoreboard of pushed jobs compared on each job_loaded.
module tb_ray_job_dispatch;
  import ray_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] in_init_x = '0;
  logic [4:0] in_init_y = '0;
  logic [4:0] in_init_z = '0;
  logic [31:0] in_timer_x = '0;
  logic [31:0] in_timer_y = '0;
  logic [31:0] in_timer_z = '0;
  logic [15:0] in_max_steps = '0;
  logic [3:0] in_job_id = '0;
  logic flush = 1'b0;
  logic fsm_ready = 1'b0;
  logic job_loaded;
  logic [4:0] job_init_x;
  logic [4:0] job_init_y;
  logic [4:0] job_init_z;
  logic [31:0] job_timer_x;
  logic [31:0] job_timer_y;
  logic [31:0] job_timer_z;
  logic [15:0] max_steps;
  logic [3:0] job_id;
  logic [3:0] jobs_pending;
  logic busy;

  ray_job_t sb[$];
  ray_job_t mon_got;
  ray_job_t mon_exp;
  int checks = 0;
  int failures = 0;
  int loaded_cnt = 0;

  always #5 clock = ~clock;

  ray_job_dispatch dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_init_x    (in_init_x),
    .in_init_y    (in_init_y),
    .in_init_z    (in_init_z),
    .in_timer_x   (in_timer_x),
    .in_timer_y   (in_timer_y),
    .in_timer_z   (in_timer_z),
    .in_max_steps (in_max_steps),
    .in_job_id    (in_job_id),
    .flush        (flush),
    .fsm_ready    (fsm_ready),
    .job_loaded   (job_loaded),
    .job_init_x   (job_init_x),
    .job_init_y   (job_init_y),
    .job_init_z   (job_init_z),
    .job_timer_x  (job_timer_x),
    .job_timer_y  (job_timer_y),
    .job_timer_z  (job_timer_z),
    .max_steps    (max_steps),
    .job_id       (job_id),
    .jobs_pending (jobs_pending),
    .busy         (busy)
  );

  // Scoreboard monitor: every start pulse must carry the oldest queued job.
  always @(negedge clock) begin
    if (!reset && job_loaded) begin
      mon_got.init_x    = job_init_x;
      mon_got.init_y    = job_init_y;
      mon_got.init_z    = job_init_z;
      mon_got.timer_x   = job_timer_x;
      mon_got.timer_y   = job_timer_y;
      mon_got.timer_z   = job_timer_z;
      mon_got.max_steps = max_steps;
      mon_got.job_id    = job_id;
      loaded_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got_id=%0d expected=no job", job_id);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL job_match got=%h expected=%h", mon_got, mon_exp);
        end
      end
    end
  end

  function automatic ray_job_t mk(input int id);
    ray_job_t j;
    j.init_x    = 5'(id * 3);
    j.init_y    = 5'(id + 4);
    j.init_z    = 5'(id ^ 5);
    j.timer_x   = 32'(id * 32'h101);
    j.timer_y   = 32'(id * 32'h2003);
    j.timer_z   = 32'hA000_0000 + 32'(id);
    j.max_steps = 16'(20 + id);
    j.job_id    = 4'(id);
    return j;
  endfunction

  task automatic push_job(input ray_job_t j);
    bit done;
    done = 1'b0;
    in_valid     = 1'b1;
    in_init_x    = j.init_x;
    in_init_y    = j.init_y;
    in_init_z    = j.init_z;
    in_timer_x   = j.timer_x;
    in_timer_y   = j.timer_y;
    in_timer_z   = j.timer_z;
    in_max_steps = j.max_steps;
    in_job_id    = j.job_id;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(j);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout id=%0d in_ready=%b expected=1", j.job_id, in_ready);
    end
  endtask

  task automatic wait_idle(input int limit);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < limit && !idle; n++) begin
      @(negedge clock);
      if (!busy) idle = 1'b1;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL idle_timeout busy=%b expected=0", busy);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || job_loaded !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs in_ready=%b job_loaded=%b expected=1 0", in_ready, job_loaded);
    end
    checks++;
    if (jobs_pending !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt pending=%0d busy=%b expected=0 0", jobs_pending, busy);
    end
    checks++;
    if (job_id !== 4'd0 || job_init_x !== 5'd0 || job_timer_x !== 32'd0 || max_steps !== 16'd0) begin
      failures++;
      $display("FAIL reset_job id=%0d x=%0d tx=%h max=%0d expected=0", job_id, job_init_x, job_timer_x, max_steps);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    ray_job_t j;
    j = '0;
    j.init_x = 5'd3;
    j.init_y = 5'd4;
    j.init_z = 5'd5;
    j.timer_x = 32'h100;
    j.max_steps = 16'd20;
    j.job_id = 4'd1;
    fsm_ready = 1'b1;
    push_job(j);
    @(negedge clock);
    checks++;
    if (job_loaded !== 1'b0 || jobs_pending !== 4'd1) begin
      failures++;
      $display("FAIL single_c1 loaded=%b pending=%0d expected=0 1", job_loaded, jobs_pending);
    end
    @(negedge clock);
    checks++;
    if (job_loaded !== 1'b1 || job_id !== 4'd1) begin
      failures++;
      $display("FAIL single_c2 loaded=%b id=%0d expected=1 1", job_loaded, job_id);
    end
    @(negedge clock);
    checks++;
    if (job_loaded !== 1'b0 || job_id !== 4'd1 || job_init_x !== 5'd3
        || job_timer_x !== 32'h100 || max_steps !== 16'd20) begin
      failures++;
      $display("FAIL single_hold loaded=%b id=%0d x=%0d tx=%h max=%0d expected=0 1 3 100 20",
               job_loaded, job_id, job_init_x, job_timer_x, max_steps);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || jobs_pending !== 4'd0) begin
      failures++;
      $display("FAIL single_done busy=%b pending=%0d expected=0 0", busy, jobs_pending);
    end
    fsm_ready = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_backpressure();
    int base;
    base = loaded_cnt;
    fsm_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_job(mk(2 + i));
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0 || jobs_pending !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_full in_ready=%b pending=%0d busy=%b expected=0 5 1", in_ready, jobs_pending, busy);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    in_job_id = 4'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || jobs_pending !== 4'd5) begin
        failures++;
        $display("FAIL bp_stall in_ready=%b pending=%0d expected=0 5", in_ready, jobs_pending);
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    fsm_ready = 1'b1;
    wait_idle(60);
    fsm_ready = 1'b0;
    checks++;
    if (loaded_cnt - base !== 5 || sb.size() !== 0) begin
      failures++;
      $display("FAIL bp_drain loaded=%0d left=%0d expected=5 0", loaded_cnt - base, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit seen;
    base = loaded_cnt;
    fsm_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_job(mk(7 + i));
    fsm_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clock);
        if (job_loaded) seen = 1'b1;
      end
      checks++;
      if (!seen || job_id !== 4'(7 + i)) begin
        failures++;
        $display("FAIL b2b_load seen=%b id=%0d expected=1 %0d", seen, job_id, 7 + i);
      end
      @(posedge clock);
      #1;
      fsm_ready = 1'b0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clock);
        checks++;
        if (job_loaded !== 1'b0) begin
          failures++;
          $display("FAIL b2b_quiet loaded=%b expected=0", job_loaded);
        end
      end
      @(posedge clock);
      #1;
      fsm_ready = 1'b1;
    end
    wait_idle(20);
    fsm_ready = 1'b0;
    checks++;
    if (loaded_cnt - base !== 3) begin
      failures++;
      $display("FAIL b2b_count loaded=%0d expected=3", loaded_cnt - base);
    end
  endtask

  task automatic test_wrap();
    int base;
    base = loaded_cnt;
    fsm_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_job(mk(10 + i));
    wait_idle(100);
    fsm_ready = 1'b0;
    checks++;
    if (loaded_cnt - base !== 10 || sb.size() !== 0) begin
      failures++;
      $display("FAIL wrap_count loaded=%0d left=%0d expected=10 0", loaded_cnt - base, sb.size());
    end
  endtask

  task automatic test_flush_present();
    fsm_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_job(mk(1 + i));
    fsm_ready = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    checks++;
    if (job_loaded !== 1'b0) begin
      failures++;
      $display("FAIL flush_present_load loaded=%b expected=0", job_loaded);
    end
    @(posedge clock);
    #1;
    sb.delete();
    flush = 1'b0;
    @(negedge clock);
    checks++;
    if (jobs_pending !== 4'd0 || busy !== 1'b0 || job_loaded !== 1'b0) begin
      failures++;
      $display("FAIL flush_present_after pending=%0d busy=%b loaded=%b expected=0 0 0",
               jobs_pending, busy, job_loaded);
    end
    fsm_ready = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_flush_hold();
    fsm_ready = 1'b0;
    push_job(mk(4));
    push_job(mk(5));
    fsm_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (job_loaded !== 1'b1) begin
      failures++;
      $display("FAIL flush_hold_load loaded=%b expected=1", job_loaded);
    end
    @(posedge clock);
    #1;
    fsm_ready = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    checks++;
    if (job_id !== 4'd4 || job_loaded !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_hold_held id=%0d loaded=%b busy=%b expected=4 0 1", job_id, job_loaded, busy);
    end
    @(posedge clock);
    #1;
    sb.delete();
    flush = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || jobs_pending !== 4'd0 || job_id !== 4'd4) begin
      failures++;
      $display("FAIL flush_hold_after busy=%b pending=%0d id=%0d expected=0 0 4", busy, jobs_pending, job_id);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    fsm_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_job(mk(6 + i));
    fsm_ready = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    fsm_ready = 1'b0;
    checks++;
    if (jobs_pending !== 4'd3) begin
      failures++;
      $display("FAIL rst_mid_pre pending=%0d expected=3", jobs_pending);
    end
    reset = 1'b1;
    #1;
    sb.delete();
    checks++;
    if (job_id !== 4'd0 || job_init_x !== 5'd0 || job_timer_z !== 32'd0 || job_loaded !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_job id=%0d x=%0d tz=%h loaded=%b expected=0", job_id, job_init_x, job_timer_z, job_loaded);
    end
    checks++;
    if (in_ready !== 1'b1 || jobs_pending !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_hs in_ready=%b pending=%0d busy=%b expected=1 0 0", in_ready, jobs_pending, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || job_loaded !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_after busy=%b loaded=%b expected=0 0", busy, job_loaded);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_flush_present();
    test_flush_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
